// File: rtl/req_encode_pkg.sv
// Shared sizes, FSM state type and popcount helper for the request encoder.
package req_encode_pkg;
  localparam int WIDTH  = 16;
  localparam int CODE_W = 4;
  localparam int CNT_W  = CODE_W + 1;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) cnt = cnt + CNT_W'(1);
    end
    return cnt;
  endfunction
endpackage

// File: rtl/req_encode16_ffs16.sv
// Highest-set-bit finder for a 16-bit vector, plus a flag for at most one bit set.
module ffs16
  import req_encode_pkg::*;
(
  input  logic [WIDTH-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              one_hot_or_zero
);

  always_comb begin
    idx = '0;
    // Ascending scan so the highest set bit overwrites lower ones.
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    one_hot_or_zero = ((vec & (vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/req_encode16.sv
// Sequential encoder: streams the index of every set request bit, highest first,
// one beat per code_valid/code_ready handshake.
module req_encode16
  import req_encode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [WIDTH-1:0]  req_vec,
  output logic              req_ready,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_last,
  output logic [CNT_W-1:0]  nbits,
  output logic              empty_pulse
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  nbits_q, nbits_d;
  logic              empty_pulse_q, empty_pulse_d;

  logic [CODE_W-1:0] top_idx;
  logic              top_only;

  ffs16 u_ffs (
    .vec             (pending_q),
    .idx             (top_idx),
    .one_hot_or_zero (top_only)
  );

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    nbits_d       = nbits_q;
    empty_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_vec != '0) begin
            pending_d = req_vec;
            nbits_d   = popcount(req_vec);
            state_d   = EMIT;
          end else begin
            nbits_d       = '0;
            empty_pulse_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (code_ready) begin
          pending_d = pending_q & ~(WIDTH'(1) << top_idx);
          if (top_only) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      nbits_q       <= '0;
      empty_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      nbits_q       <= nbits_d;
      empty_pulse_q <= empty_pulse_d;
    end
  end

  // Ready is held low during reset even though the state already reads IDLE.
  assign req_ready   = (state_q == IDLE) && !rst;
  assign code_valid  = (state_q == EMIT);
  assign code        = top_idx;
  assign code_last   = (state_q == EMIT) && top_only;
  assign nbits       = nbits_q;
  assign empty_pulse = empty_pulse_q;

endmodule

// File: tb/tb_req_encode16.sv
// Directed bench for req_encode16: hand-computed beat sequences, stalls and reset.
module tb_req_encode16;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_vec;
  logic        req_ready;
  logic        code_valid;
  logic        code_ready;
  logic [3:0]  code;
  logic        code_last;
  logic [4:0]  nbits;
  logic        empty_pulse;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] got_codes[$];
  bit         got_last[$];
  logic [3:0] held[$];
  int         exp_codes[$];
  int         occ;

  req_encode16 dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_vec     (req_vec),
    .req_ready   (req_ready),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .code        (code),
    .code_last   (code_last),
    .nbits       (nbits),
    .empty_pulse (empty_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] vec);
    req_valid = 1'b1;
    req_vec   = vec;
    step();
    req_valid = 1'b0;
  endtask

  // mode 0: ready always high; 1: low 5 cycles then toggling; 2: ready high while
  // req_valid stays high with a changing req_vec.
  task automatic collect(input int mode);
    int cyc;
    got_codes.delete();
    got_last.delete();
    held.delete();
    cyc = 0;
    while (!req_ready && cyc < 60) begin
      case (mode)
        1: code_ready = (cyc < 5) ? 1'b0 : (((cyc - 5) % 2) == 0);
        2: begin
          code_ready = 1'b1;
          req_valid  = 1'b1;
          req_vec    = 16'hA5A5 ^ 16'(cyc * 16'h0111);
        end
        default: code_ready = 1'b1;
      endcase
      if (code_valid && code_ready) begin
        got_codes.push_back(code);
        got_last.push_back(code_last);
      end
      if (code_valid && !code_ready && cyc < 5) held.push_back(code);
      step();
      cyc++;
    end
    if (!req_ready) check("timeout_req_ready", {31'd0, req_ready}, 32'd1);
    occ = cyc + 1;
    code_ready = 1'b0;
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_nbeats"}, got_codes.size(), exp_codes.size());
    for (int i = 0; i < exp_codes.size() && i < got_codes.size(); i++) begin
      check($sformatf("%s_code%0d", tag, i), {28'd0, got_codes[i]}, exp_codes[i]);
      check($sformatf("%s_last%0d", tag, i), {31'd0, got_last[i]},
            (i == exp_codes.size() - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_vec    = '0;
    code_ready = 1'b0;
    step();
    step();
    check("ready_in_rst", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    step();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, code_valid}, 32'd0);
    check("rst_code", {28'd0, code}, 32'd0);
    check("rst_last", {31'd0, code_last}, 32'd0);
    check("rst_nbits", {27'd0, nbits}, 32'd0);
    check("rst_empty", {31'd0, empty_pulse}, 32'd0);

    // 0x8001: codes 15, 0
    accept(16'h8001);
    check("v8001_first_valid", {31'd0, code_valid}, 32'd1);
    check("v8001_nbits", {27'd0, nbits}, 32'd2);
    check("v8001_ready_low", {31'd0, req_ready}, 32'd0);
    collect(0);
    exp_codes = '{15, 0};
    compare_beats("v8001");
    check("v8001_occupancy", occ, 32'd3);

    // all-zero vector
    accept(16'h0000);
    check("zero_empty_pulse", {31'd0, empty_pulse}, 32'd1);
    check("zero_nbits", {27'd0, nbits}, 32'd0);
    check("zero_valid", {31'd0, code_valid}, 32'd0);
    check("zero_ready", {31'd0, req_ready}, 32'd1);
    step();
    check("zero_empty_drop", {31'd0, empty_pulse}, 32'd0);
    check("zero_valid2", {31'd0, code_valid}, 32'd0);

    // 0xFFFF: 16 back-to-back beats
    accept(16'hFFFF);
    check("vffff_nbits", {27'd0, nbits}, 32'd16);
    collect(0);
    exp_codes = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    compare_beats("vffff");
    check("vffff_occupancy", occ, 32'd17);
    check("vffff_nbits_hold", {27'd0, nbits}, 32'd16);

    // 0x0124 with stall then toggling ready
    accept(16'h0124);
    check("v0124_nbits", {27'd0, nbits}, 32'd3);
    collect(1);
    check("v0124_held_n", held.size(), 32'd5);
    for (int i = 0; i < held.size(); i++)
      check($sformatf("v0124_held%0d", i), {28'd0, held[i]}, 32'd8);
    exp_codes = '{8, 5, 2};
    compare_beats("v0124");

    // reset during beat 2 of 0x00F0
    accept(16'h00F0);
    code_ready = 1'b1;
    step();
    check("v00f0_beat2_code", {28'd0, code}, 32'd6);
    check("v00f0_beat2_valid", {31'd0, code_valid}, 32'd1);
    rst = 1'b1;
    step();
    check("midrst_ready_in_rst", {31'd0, req_ready}, 32'd0);
    check("midrst_valid_in_rst", {31'd0, code_valid}, 32'd0);
    rst = 1'b0;
    code_ready = 1'b0;
    #1;
    check("midrst_valid", {31'd0, code_valid}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_nbits", {27'd0, nbits}, 32'd0);
    check("midrst_last", {31'd0, code_last}, 32'd0);
    accept(16'h0002);
    check("v0002_valid", {31'd0, code_valid}, 32'd1);
    check("v0002_code", {28'd0, code}, 32'd1);
    check("v0002_last", {31'd0, code_last}, 32'd1);
    check("v0002_nbits", {27'd0, nbits}, 32'd1);
    code_ready = 1'b1;
    step();
    code_ready = 1'b0;
    check("v0002_done_valid", {31'd0, code_valid}, 32'd0);
    check("v0002_done_ready", {31'd0, req_ready}, 32'd1);

    // req_valid held high with changing req_vec during EMIT of 0x0300
    accept(16'h0300);
    collect(2);
    exp_codes = '{9, 8};
    compare_beats("v0300");
    check("v0300_nbits", {27'd0, nbits}, 32'd2);
    req_valid = 1'b1;
    req_vec   = 16'h0010;
    step();
    req_valid = 1'b0;
    check("next_code", {28'd0, code}, 32'd4);
    check("next_last", {31'd0, code_last}, 32'd1);
    check("next_nbits", {27'd0, nbits}, 32'd1);
    collect(0);
    exp_codes = '{4};
    compare_beats("next");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/req_encode16.md
Name: req_encode16

Overview:
- Sequential encoder: the opposite direction of the team's 3-bit-to-one-hot decoder.
- Accepts a 16-bit request vector with any number of bits set.
- Emits the 4-bit binary index of each set bit as a stream of beats, one per handshake, highest index first.
- Feeds request/interrupt vectors from the one-hot side of the design back into binary-coded consumers.

Parameters:
- WIDTH, 16, number of request lines. Fixed at 16 for this revision.
- CODE_W, 4, code width. Equals log2(WIDTH); derived, not overridden.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- req_valid  in  1  req_vec is valid.
- req_vec  in  16  Request vector; bit i set means index i is requested.
- req_ready  out  1  Block can accept a vector.
- code_valid  out  1  code holds a valid index.
- code_ready  in  1  Consumer accepts code this cycle.
- code  out  4  Binary index of the highest set bit still pending.
- code_last  out  1  Current beat is the final index of this vector.
- nbits  out  5  Popcount of the accepted vector, 0..16; held until the next accept.
- empty_pulse  out  1  One-cycle pulse when an all-zero vector is accepted.

Behaviour:
- Reset values: state IDLE, pending=0, code_valid=0, code=0, code_last=0, nbits=0, empty_pulse=0, req_ready=1 in the cycle after rst deasserts.
- While rst is high, req_ready=0.
- States are IDLE and EMIT.
- req_ready is 1 only in IDLE. No overlap between consecutive vectors.
- IDLE, req_valid=1, req_vec!=0:
  - pending <= req_vec; nbits <= popcount(req_vec); go to EMIT.
  - code_valid rises on the next cycle (accept-to-first-beat latency 1).
- IDLE, req_valid=1, req_vec==0:
  - Vector is accepted and discarded.
  - nbits <= 0; empty_pulse=1 on the next cycle only; stay in IDLE.
  - No code beat is emitted.
- EMIT:
  - code_valid=1.
  - code = index of highest set bit of pending (bit 15 has highest priority).
  - code_last=1 when exactly one bit of pending is set.
  - code and code_last are combinational from the registered pending only. Both stay stable while code_valid=1 and code_ready=0.
- EMIT, code_ready=1:
  - Clear bit [code] of pending.
  - If code_last=1, go to IDLE: code_valid=0 and req_ready=1 on the next cycle.
  - Otherwise the next beat is presented on the next cycle.
- Throughput: one beat per cycle under continuous code_ready. A vector with k set bits occupies k+1 cycles from accept to the next req_ready.
- code_ready=0 stalls indefinitely with no loss. Ready toggling per cycle must still deliver every index exactly once, in descending order.
- req_valid in EMIT is ignored. The upstream must hold its vector (valid/ready rule: transfer only when both are high).
- Inputs in EMIT are not sampled: req_vec changes there have no effect.
- rst mid-EMIT: pending is discarded, no further beats, all outputs return to their reset values on the next edge.
- nbits=16 (all bits set) must not wrap; 5-bit width is required.

Decomposition:
- Package req_encode_pkg:
  - WIDTH=16, CODE_W=4.
  - State enum {IDLE, EMIT}.
  - Popcount function.
- One combinational sub-module, ffs16: 16-bit in, 4-bit index of highest set bit, plus a one_hot_or_zero flag used for code_last.
- The top level holds the FSM, the pending register and the handshake.

Test Plan:
- Reset, then req_vec=16'h8001 with code_ready=1:
  - codes 15 then 0; code_last on the second beat only.
  - nbits=2; req_ready returns 3 cycles after accept.
- req_vec=16'h0000:
  - no code_valid; empty_pulse high exactly 1 cycle; nbits=0.
- req_vec=16'hFFFF with continuous ready:
  - 16 beats, codes 15 down to 0, back to back.
  - nbits=16; code_last only on code 0.
- req_vec=16'h0124 with code_ready held 0 for 5 cycles, then toggled 1/0:
  - code holds 8 while stalled.
  - Sequence is 8, 5, 2 with no duplicates or drops.
- Assert rst during beat 2 of 16'h00F0:
  - Next cycle code_valid=0, req_ready=1, nbits=0.
  - A following 16'h0002 yields the single code 1 with code_last=1.
- req_valid held high with changing req_vec during EMIT of 16'h0300:
  - Only codes 9, 8 are emitted.
  - The next vector is accepted only in IDLE.
